// File: rtl/ifetch_ctrl_pkg.sv
// ifetch_ctrl_pkg
//   Shared definitions for the instruction fetch controller: the NOP word used
//   in fault entries, instruction exception codes (also consumed by trap/CSR
//   logic), the fetch FSM state type and the instruction queue entry layout.
//   No ports.
package ifetch_ctrl_pkg;

   localparam logic [31:0] INSN_NOP             = 32'h0000_0013;
   localparam logic [3:0]  EXC_INSTR_MISALIGNED = 4'd0;
   localparam logic [3:0]  EXC_INSTR_ACCESS     = 4'd1;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic        exc_en;
      logic [3:0]  exc_code;
      logic [63:0] exc_val;
      logic [63:0] pc;
      logic [31:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if
//   Bundles the fetch controller's redirect input, instruction memory port and
//   decode handshake.
//   master : controller side (drives mem_req/mem_addr and the inst_* outputs)
//   slave  : environment side (memory, decode, redirect source)
interface ifetch_ctrl_if;

   logic        redirect_valid;
   logic [63:0] redirect_pc;

   logic        mem_req;
   logic [63:0] mem_addr;
   logic [31:0] mem_rdata;

   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [63:0] inst_pc;
   logic        inst_exc_en;
   logic [3:0]  inst_exc_code;
   logic [63:0] inst_exc_val;

   modport master (
      input  redirect_valid, redirect_pc, mem_rdata, inst_ready,
      output mem_req, mem_addr, inst_valid, inst_data, inst_pc,
             inst_exc_en, inst_exc_code, inst_exc_val
   );

   modport slave (
      output redirect_valid, redirect_pc, mem_rdata, inst_ready,
      input  mem_req, mem_addr, inst_valid, inst_data, inst_pc,
             inst_exc_en, inst_exc_code, inst_exc_val
   );

endinterface

// File: rtl/ifetch_ctrl_queue.sv
// ifetch_ctrl_queue
//   Synchronous FIFO of fetch entries between the fetch logic and decode.
//   clk, rst   : clock, synchronous active-high reset (empties the queue)
//   push/entry : write an entry (accepted when not full, or full with a pop)
//   pop        : remove the head (ignored when empty)
//   flush      : empty the queue; wins over a same-cycle push
//   head       : current head entry (undefined contents when empty)
//   full/empty/count : occupancy
module ifetch_ctrl_queue
   import ifetch_ctrl_pkg::*;
#(
   parameter int unsigned QDEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  fetch_entry_t              push_entry,
   input  logic                      pop,
   input  logic                      flush,
   output fetch_entry_t              head,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(QDEPTH):0]   count
);

   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t    store_q [QDEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            pop_ok;
   logic            push_ok;

   assign full   = (count_q == CW'(QDEPTH));
   assign empty  = (count_q == '0);
   assign count  = count_q;
   assign head   = store_q[rd_ptr_q];

   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush)
         store_q[wr_ptr_q] <= push_entry;
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl
//   Instruction fetch controller. Owns the fetch PC, issues word reads to a
//   1-cycle-latency memory, buffers results in ifetch_ctrl_queue and presents
//   them to decode over valid/ready. Redirects flush and restart fetch; a
//   misaligned or out-of-range PC yields a single NOP fault entry and halts.
//   clk, rst : clock, synchronous active-high reset
//   bus      : redirect, memory port and decode handshake (master side)
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_RUN  | fetching sequentially from fetch_pc while credit allows
//   ST_HALT | fault entry generated; no fetch until the next redirect
module ifetch_ctrl
   import ifetch_ctrl_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int unsigned MEM_WORDS = 2048,
   parameter int unsigned QDEPTH    = 2
) (
   input  logic         clk,
   input  logic         rst,
   ifetch_ctrl_if.master bus
);

   localparam int CW = $clog2(QDEPTH) + 1;

   fetch_state_e   state_q, state_d;
   logic [63:0]    fetch_pc_q, fetch_pc_d;
   logic [63:0]    resp_pc_q, resp_pc_d;
   logic           inflight_q, inflight_d;
   logic           drop_q, drop_d;

   fetch_entry_t   q_head;
   fetch_entry_t   q_push_entry;
   logic           q_full;
   logic           q_empty;
   logic [CW-1:0]  q_count;
   logic           q_push;

   logic           redirect;
   logic           inst_valid;
   logic           pop;
   logic [CW:0]    used_slots;
   logic [CW:0]    slot_limit;
   logic           credit_ok;
   logic           misaligned;
   logic           out_of_range;
   logic           can_issue;
   logic           issue_mem;
   logic           issue_fault;
   logic           resp_push;

   assign redirect   = bus.redirect_valid & ~rst;
   assign inst_valid = ~q_empty & ~rst;
   assign pop        = inst_valid & bus.inst_ready;

   // count + inflight - pop < QDEPTH, rearranged to stay unsigned
   assign used_slots = {1'b0, q_count} + (CW+1)'(inflight_q);
   assign slot_limit = (CW+1)'(QDEPTH) + (CW+1)'(pop);
   assign credit_ok  = used_slots < slot_limit;

   // Full-width word index compare so huge PCs never alias into memory
   assign misaligned   = |fetch_pc_q[1:0];
   assign out_of_range = {2'b00, fetch_pc_q[63:2]} >= 64'(MEM_WORDS);

   assign can_issue   = ~rst & ~redirect & (state_q == ST_RUN) & credit_ok;
   assign issue_mem   = can_issue & ~misaligned & ~out_of_range;
   // Waiting for !inflight keeps the fault entry behind the older response
   assign issue_fault = can_issue & (misaligned | out_of_range) & ~inflight_q;

   assign resp_push = inflight_q & ~drop_q;
   assign q_push    = resp_push | issue_fault;

   always_comb begin
      q_push_entry = '0;
      if (resp_push) begin
         q_push_entry.pc   = resp_pc_q;
         q_push_entry.data = bus.mem_rdata;
      end else begin
         q_push_entry.exc_en   = 1'b1;
         q_push_entry.exc_code = misaligned ? EXC_INSTR_MISALIGNED : EXC_INSTR_ACCESS;
         q_push_entry.exc_val  = fetch_pc_q;
         q_push_entry.pc       = fetch_pc_q;
         q_push_entry.data     = INSN_NOP;
      end
   end

   ifetch_ctrl_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (q_push),
      .push_entry (q_push_entry),
      .pop        (pop),
      .flush      (redirect),
      .head       (q_head),
      .full       (q_full),
      .empty      (q_empty),
      .count      (q_count)
   );

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      inflight_d = issue_mem;
      drop_d     = 1'b0;
      if (issue_mem) begin
         fetch_pc_d = fetch_pc_q + 64'd4;
         resp_pc_d  = fetch_pc_q;
      end
      if (issue_fault)
         state_d = ST_HALT;
      if (redirect) begin
         state_d    = ST_RUN;
         fetch_pc_d = bus.redirect_pc;
         inflight_d = 1'b0;
         drop_d     = inflight_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= '0;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   assign bus.mem_req       = issue_mem;
   assign bus.mem_addr      = issue_mem ? fetch_pc_q : 64'h0;
   assign bus.inst_valid    = inst_valid;
   assign bus.inst_data     = inst_valid ? q_head.data     : 32'h0;
   assign bus.inst_pc       = inst_valid ? q_head.pc       : 64'h0;
   assign bus.inst_exc_en   = inst_valid ? q_head.exc_en   : 1'b0;
   assign bus.inst_exc_code = inst_valid ? q_head.exc_code : 4'h0;
   assign bus.inst_exc_val  = inst_valid ? q_head.exc_val  : 64'h0;

   logic unused_full;
   assign unused_full = q_full;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl
//   Self-checking bench for ifetch_ctrl: directed scenarios followed by a
//   randomized phase, all checked against an in-order instruction stream model.
module tb_ifetch_ctrl;
   import ifetch_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ifetch_ctrl_if bus();

   ifetch_ctrl #(.RESET_PC(64'h0), .MEM_WORDS(2048), .QDEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] mem [2048];
   always @(posedge clk)
      if (bus.mem_req) bus.mem_rdata <= mem[bus.mem_addr[12:2]];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Model: decode must see PCs exp_pc, exp_pc+4, ... in order until a fault
   // entry, then nothing until a redirect or reset restarts the stream.
   logic [63:0] exp_pc;
   bit          halted;
   int          stall;

   logic        s_req, s_valid, s_exc_en;
   logic [63:0] s_addr, s_pc, s_val;
   logic [31:0] s_data;
   logic [3:0]  s_code;

   task automatic check_transfer();
      logic        e_exc;
      logic [3:0]  e_code;
      logic [31:0] e_data;
      logic [63:0] e_val;
      if (halted) begin
         chk("xfer_while_halted", 64'(s_valid), 64'd0);
         return;
      end
      e_exc = 1'b0; e_code = 4'd0; e_val = 64'd0;
      if (exp_pc[1:0] != 2'b00) begin
         e_exc = 1'b1; e_code = 4'd0; e_val = exp_pc; e_data = 32'h13;
      end else if (exp_pc / 4 >= 64'd2048) begin
         e_exc = 1'b1; e_code = 4'd1; e_val = exp_pc; e_data = 32'h13;
      end else begin
         e_data = mem[exp_pc[12:2]];
      end
      chk("xfer_pc", s_pc, exp_pc);
      chk("xfer_data", 64'(s_data), 64'(e_data));
      chk("xfer_exc_en", 64'(s_exc_en), 64'(e_exc));
      chk("xfer_exc_code", 64'(s_code), 64'(e_code));
      chk("xfer_exc_val", s_val, e_val);
      if (e_exc) halted = 1'b1;
      else       exp_pc = exp_pc + 64'd4;
   endtask

   task automatic step(input bit r, input bit rdy, input bit rv, input logic [63:0] rpc);
      @(posedge clk);
      #1;
      rst                = r;
      bus.inst_ready     = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      @(negedge clk);
      s_req = bus.mem_req;       s_addr = bus.mem_addr;
      s_valid = bus.inst_valid;  s_data = bus.inst_data;  s_pc = bus.inst_pc;
      s_exc_en = bus.inst_exc_en; s_code = bus.inst_exc_code; s_val = bus.inst_exc_val;
      if (r) begin
         chk("rst_req", 64'(s_req), 64'd0);
         chk("rst_valid", 64'(s_valid), 64'd0);
         exp_pc = 64'h0; halted = 1'b0; stall = 0;
      end else begin
         if (s_req) begin
            chk("req_aligned", 64'(s_addr[1:0]), 64'd0);
            chk("req_in_range", 64'(s_addr < 64'h2000), 64'd1);
         end
         if (rv) chk("req_on_redirect", 64'(s_req), 64'd0);
         if (!s_valid)
            chk("idle_zero", s_pc | s_val | 64'(s_data) | 64'({s_exc_en, s_code}), 64'd0);
         if (s_valid && rdy) begin
            check_transfer();
            stall = 0;
         end else if (rdy && !halted) begin
            stall++;
            if (stall == 5) chk("stream_stall", 64'(stall), 64'd4);
         end
         if (rv) begin
            exp_pc = rpc; halted = 1'b0; stall = 0;
         end
      end
   endtask

   initial begin
      logic [63:0] tgt;
      int          k;
      rst = 1'b1;
      bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 64'h0;
      for (int i = 0; i < 2048; i++) mem[i] = $urandom;
      mem[0] = 32'h0010_0093;
      exp_pc = 64'h0; halted = 1'b0; stall = 0;

      // 1. reset then first fetch
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("t1_req", 64'(s_req), 64'd1);
      chk("t1_addr", s_addr, 64'h0);
      chk("t1_valid_early", 64'(s_valid), 64'd0);
      step(0, 1, 0, 0);
      chk("t1_valid_mid", 64'(s_valid), 64'd0);
      step(0, 1, 0, 0);
      chk("t1_valid", 64'(s_valid), 64'd1);
      chk("t1_pc", s_pc, 64'h0);
      chk("t1_data", 64'(s_data), 64'h0010_0093);

      // 2. streaming
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 0);
         chk("t2_valid", 64'(s_valid), 64'd1);
         chk("t2_req", 64'(s_req), 64'd1);
         chk("t2_pc", s_pc, 64'(4 * (i + 1)));
      end

      // 3. back-pressure then release
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 0);
         chk("t3_valid", 64'(s_valid), 64'd1);
         if (i >= 1) chk("t3_req", 64'(s_req), 64'd0);
      end
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 0, 0);
         chk("t3_resume_valid", 64'(s_valid), 64'd1);
      end

      // 4. redirect with a response in flight
      step(0, 1, 1, 64'h40);
      step(0, 1, 0, 0);
      chk("t4_req", 64'(s_req), 64'd1);
      chk("t4_addr", s_addr, 64'h40);
      k = 0;
      while (!s_valid && k < 6) begin step(0, 1, 0, 0); k++; end
      chk("t4_pc", s_pc, 64'h40);

      // 5. access fault, halt, resume
      step(0, 1, 1, 64'h2000);
      k = 0;
      do begin
         step(0, 1, 0, 0);
         chk("t5_noreq", 64'(s_req), 64'd0);
         k++;
      end while (!s_valid && k < 6);
      chk("t5_exc_en", 64'(s_exc_en), 64'd1);
      chk("t5_code", 64'(s_code), 64'd1);
      chk("t5_val", s_val, 64'h2000);
      chk("t5_data", 64'(s_data), 64'h13);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 0);
         chk("t5_halt_req", 64'(s_req), 64'd0);
         chk("t5_halt_valid", 64'(s_valid), 64'd0);
      end
      step(0, 1, 1, 64'h0);
      step(0, 1, 0, 0);
      chk("t5_resume_req", 64'(s_req), 64'd1);
      chk("t5_resume_addr", s_addr, 64'h0);

      // 6. misaligned fault, then reset with a full queue
      step(0, 1, 1, 64'h6);
      k = 0;
      do begin step(0, 1, 0, 0); k++; end while (!s_valid && k < 6);
      chk("t6_exc_en", 64'(s_exc_en), 64'd1);
      chk("t6_code", 64'(s_code), 64'd0);
      chk("t6_val", s_val, 64'h6);
      step(0, 0, 1, 64'h0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
      chk("t6_full_valid", 64'(s_valid), 64'd1);
      chk("t6_full_req", 64'(s_req), 64'd0);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("t6_post_valid", 64'(s_valid), 64'd0);
      chk("t6_post_req", 64'(s_req), 64'd1);
      chk("t6_post_addr", s_addr, 64'h0);

      // randomized phase
      for (int i = 0; i < 1500; i++) begin
         bit r, rdy, rv;
         r   = ($urandom_range(0, 149) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 9))
            0:       tgt = 64'($urandom_range(0, 2047)) * 4 + 64'($urandom_range(1, 3));
            1:       tgt = 64'h2000 + 64'($urandom_range(0, 100)) * 4;
            2:       tgt = 64'h1_0000_0000;
            3:       tgt = 64'(2048 - $urandom_range(1, 6)) * 4;
            default: tgt = 64'($urandom_range(0, 2047)) * 4;
         endcase
         step(r, rdy, rv, tgt);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
